// File: rtl/gpio_pattern_gen.sv
// rtl/gpio_pattern_gen.sv - multi-channel GPIO pattern generator (off/square/PWM/one-shot)
// Each channel keeps its own mode, period, high time, counter and output/done flops.
module gpio_pattern_gen #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 27,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cfg_valid,
  input  logic [CH_W-1:0]     i_cfg_ch,
  input  logic [1:0]          i_cfg_mode,
  input  logic [CNT_W-1:0]    i_cfg_period,
  input  logic [CNT_W-1:0]    i_cfg_high,
  input  logic                i_hold,
  input  logic                i_sync,
  output logic [CHANNELS-1:0] o_gpio,
  output logic [CHANNELS-1:0] o_done
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SQUARE  = 2'd1,
    MODE_PWM     = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_t;

  // Output level of a freshly (re)started pattern at cnt == 0.
  function automatic logic start_level(input mode_t mode, input logic [CNT_W-1:0] high);
    case (mode)
      MODE_PWM, MODE_ONESHOT: start_level = (high != '0);
      default:                start_level = 1'b0;
    endcase
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    mode_t            mode_q, mode_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_wrap;
    logic             level_q, level_d;
    logic             done_q, done_d;
    logic             sel;
    mode_t            cfg_mode;

    // Indices with no matching channel select nothing, so such writes drop out.
    assign sel      = i_cfg_valid && (int'(i_cfg_ch) == c);
    assign cfg_mode = mode_t'(i_cfg_mode);
    assign cnt_inc  = cnt_q + 1'b1;
    assign cnt_wrap = (cnt_q == period_q) ? '0 : cnt_inc;

    always_comb begin
      mode_d   = mode_q;
      period_d = period_q;
      high_d   = high_q;
      cnt_d    = cnt_q;
      level_d  = level_q;
      done_d   = done_q;

      if (sel) begin
        // A write beats sync, hold and any pending one-shot completion.
        mode_d   = cfg_mode;
        period_d = i_cfg_period;
        high_d   = i_cfg_high;
        cnt_d    = '0;
        level_d  = start_level(cfg_mode, i_cfg_high);
        done_d   = 1'b0;
        if (cfg_mode == MODE_ONESHOT && i_cfg_high == '0) begin
          mode_d = MODE_OFF;
          done_d = 1'b1;
        end
      end else if (i_sync && mode_q != MODE_OFF) begin
        cnt_d   = '0;
        level_d = start_level(mode_q, high_q);
        done_d  = 1'b0;
      end else if (!i_hold) begin
        case (mode_q)
          MODE_SQUARE: begin
            cnt_d  = cnt_wrap;
            done_d = 1'b0;
            if (cnt_q == period_q) level_d = !level_q;
          end
          MODE_PWM: begin
            cnt_d   = cnt_wrap;
            level_d = (cnt_wrap < high_q);
            done_d  = 1'b0;
          end
          MODE_ONESHOT: begin
            if (cnt_inc == high_q) begin
              mode_d  = MODE_OFF;
              cnt_d   = '0;
              level_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              cnt_d  = cnt_inc;
              done_d = 1'b0;
            end
          end
          default: begin
            cnt_d   = '0;
            level_d = 1'b0;
            done_d  = 1'b0;
          end
        endcase
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        mode_q   <= MODE_OFF;
        period_q <= '0;
        high_q   <= '0;
        cnt_q    <= '0;
        level_q  <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        mode_q   <= mode_d;
        period_q <= period_d;
        high_q   <= high_d;
        cnt_q    <= cnt_d;
        level_q  <= level_d;
        done_q   <= done_d;
      end
    end

    assign o_gpio[c] = level_q;
    assign o_done[c] = done_q;
  end

endmodule

// File: tb/tb_gpio_pattern_gen.sv
// tb/tb_gpio_pattern_gen.sv - directed self-checking bench for gpio_pattern_gen
module tb_gpio_pattern_gen;
  localparam int CNT_W = 27;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic [1:0]       cfg_ch = '0;
  logic [1:0]       cfg_mode = '0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic [CNT_W-1:0] cfg_high = '0;
  logic             hold = 1'b0;
  logic             sync = 1'b0;
  logic [3:0]       gpio, done;
  logic [2:0]       gpio3, done3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_pattern_gen #(.CHANNELS(4), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .i_cfg_ch(cfg_ch),
    .i_cfg_mode(cfg_mode), .i_cfg_period(cfg_period), .i_cfg_high(cfg_high),
    .i_hold(hold), .i_sync(sync), .o_gpio(gpio), .o_done(done)
  );

  gpio_pattern_gen #(.CHANNELS(3), .CNT_W(CNT_W)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .i_cfg_ch(cfg_ch),
    .i_cfg_mode(cfg_mode), .i_cfg_period(cfg_period), .i_cfg_high(cfg_high),
    .i_hold(hold), .i_sync(sync), .o_gpio(gpio3), .o_done(done3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge after the write edge, i.e. in the first new-pattern cycle.
  task automatic write(input int ch, input int mode, input int p, input int h, input logic s);
    cfg_ch     = 2'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = CNT_W'(p);
    cfg_high   = CNT_W'(h);
    cfg_valid  = 1'b1;
    sync       = s;
    @(negedge clk);
    cfg_valid  = 1'b0;
    sync       = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // reset with garbage config traffic
    for (int i = 0; i < 3; i++) begin
      cfg_valid  = 1'b1;
      cfg_ch     = 2'($urandom);
      cfg_mode   = 2'($urandom);
      cfg_period = CNT_W'($urandom_range(0, 5));
      cfg_high   = CNT_W'($urandom_range(0, 5));
      sync       = 1'($urandom);
      @(negedge clk);
      check("rst_gpio", gpio, 0);
      check("rst_done", done, 0);
    end
    cfg_valid = 1'b0;
    sync = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_gpio", gpio, 0);
      check("post_rst_done", done, 0);
    end

    // square P=3 then P=0
    write(0, 1, 3, 0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check("sq_p3", gpio[0], (i / 4) % 2);
      @(negedge clk);
    end
    write(0, 1, 0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check("sq_p0", gpio[0], i % 2);
      @(negedge clk);
    end

    // PWM P=9 with H=3, H=0, H=12
    write(1, 2, 9, 3, 1'b0);
    for (int i = 0; i < 20; i++) begin
      check("pwm_h3", gpio[1], (i % 10) < 3);
      @(negedge clk);
    end
    write(1, 2, 9, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      check("pwm_h0", gpio[1], 0);
      @(negedge clk);
    end
    write(1, 2, 9, 12, 1'b0);
    for (int i = 0; i < 12; i++) begin
      check("pwm_h12", gpio[1], 1);
      @(negedge clk);
    end

    // one-shot H=5 and H=0
    write(2, 3, 0, 5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("os_gpio", gpio[2], i < 5);
      check("os_done", done[2], i == 5);
      @(negedge clk);
    end
    write(2, 3, 0, 0, 1'b0);
    check("os0_done", done[2], 1);
    check("os0_gpio", gpio[2], 0);
    @(negedge clk);
    check("os0_done_clr", done[2], 0);

    // hold 7 cycles mid-PWM
    write(1, 2, 9, 3, 1'b0);
    check("hold_pre0", gpio[1], 1);
    @(negedge clk);
    check("hold_pre1", gpio[1], 1);
    hold = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("hold_frozen", gpio[1], 1);
    end
    hold = 1'b0;
    for (int i = 2; i < 14; i++) begin
      @(negedge clk);
      check("hold_resume", gpio[1], (i % 10) < 3);
    end

    // sync together with a write to ch3
    write(0, 1, 3, 0, 1'b0);
    write(1, 2, 9, 3, 1'b0);
    write(2, 3, 0, 5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    write(3, 1, 1, 0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      check("sync_ch0", gpio[0], (i / 4) % 2);
      check("sync_ch1", gpio[1], (i % 10) < 3);
      check("sync_ch2", gpio[2], i < 5);
      check("sync_ch2_done", done[2], i == 5);
      check("sync_ch3", gpio[3], (i / 2) % 2);
      @(negedge clk);
    end

    // config lands in the final one-shot cycle
    write(2, 3, 0, 2, 1'b0);
    check("last_os0", gpio[2], 1);
    @(negedge clk);
    check("last_os1", gpio[2], 1);
    write(2, 2, 9, 3, 1'b0);
    for (int i = 0; i < 7; i++) begin
      check("last_gpio", gpio[2], i < 3);
      check("last_done", done[2], 0);
      @(negedge clk);
    end

    // config accepted during hold, pattern starts when hold drops
    hold = 1'b1;
    write(1, 1, 1, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("hold_cfg", gpio[1], 0);
      @(negedge clk);
    end
    hold = 1'b0;
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      check("hold_cfg_run", gpio[1], (i / 2) % 2);
    end

    // reset during a one-shot high phase
    write(2, 3, 0, 6, 1'b0);
    check("rst_os_pre", gpio[2], 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_gpio", gpio, 0);
    check("rst_mid_done", done, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_after_gpio", gpio, 0);
      check("rst_after_done", done, 0);
    end

    // out-of-range channel on a 3-channel instance
    write(3, 3, 0, 0, 1'b0);
    check("oor_ref_done", done[3], 1);
    check("oor_done", done3, 0);
    check("oor_gpio", gpio3, 0);
    write(3, 1, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("oor_sq_gpio", gpio3, 0);
      check("ref_sq_gpio", gpio[3], i % 2);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpio_pattern_gen.md
# gpio_pattern_gen

Multi-channel GPIO pattern generator that replaces the single fixed-rate toggler. Each channel is independently configured at runtime for off, square-wave, PWM or one-shot pulse output, with a programmable period and high time. A global hold and a global resync align or freeze all channels. The block sits between the control FSM or host registers and the board GPIO header pins.

## Interface
- CHANNELS, 4: number of independent output channels (1..16)
- CNT_W, 27: width of the period and high-time counters (27 covers 50 000 000 at 50 MHz)
- CH_W, $clog2(CHANNELS) (minimum 1): width of the channel select

- i_clk  in  1  system clock; all logic on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_cfg_valid  in  1  one-cycle configuration write strobe
- i_cfg_ch  in  CH_W  target channel; writes with index ≥ CHANNELS are ignored
- i_cfg_mode  in  2  0 OFF, 1 SQUARE, 2 PWM, 3 ONESHOT
- i_cfg_period  in  CNT_W  P: SQUARE half-period is P+1 cycles; PWM frame is P+1 cycles
- i_cfg_high  in  CNT_W  H: high cycles per PWM frame, or ONESHOT pulse length
- i_hold  in  1  while high, every channel's counter and output freeze
- i_sync  in  1  one-cycle pulse; restarts every non-OFF channel at count 0
- o_gpio  out  CHANNELS  pattern outputs, driven directly from flops
- o_done  out  CHANNELS  one-cycle pulse when a ONESHOT channel finishes

## Operation
Per channel, the block holds these registers: mode, P, H, cnt (CNT_W bits), level, and done.

- **Reset:** all modes are OFF, cnt=0, o_gpio=0, o_done=0. Reset overrides every other input, including mid-pattern.
- **Config write:** on an edge with i_cfg_valid high, the selected channel loads mode, P and H. It also sets cnt=0 and restarts its pattern. The output level from the next cycle follows the new mode's rules at cnt=0. Other channels are unaffected.
- **OFF:** o_gpio=0, the counter is idle, and o_done=0.
- **SQUARE:** after config, the output is 0. cnt counts from 0 to P. In the cycle where cnt==P, the level inverts and cnt returns to 0. The output period is 2(P+1) cycles. P=0 toggles the output every cycle.
- **PWM:** cnt counts 0..P and then wraps. The output is high for the first H cycles of each frame and low for the rest.
  - H=0: the output is constantly 0.
  - H>P: the output is constantly 1.
  - The duty update takes effect on the next cycle because of the config restart.
- **ONESHOT:** the output is high for exactly H cycles, starting the cycle after the config write. It is then low.
  - o_done pulses for one cycle in the first low cycle, and the mode then reverts to OFF.
  - H=0: there is no high cycle, and o_done pulses in the cycle after the write.
- **Counter arithmetic:** counters are unsigned CNT_W bits and never pass P. With P = 2^CNT_W−1, cnt wraps naturally with no overflow flag.

## Timing
- Config-to-output latency is 1 cycle: write at edge E0, and the new pattern's first cycle is visible after E0.
- **i_hold:** cnt, level and done stay frozen, and o_gpio holds its value.
  - A config write during hold is still accepted. That channel sits at cnt=0 and shows its start level until hold drops.
  - An i_sync during hold is also applied.
- **i_sync:** every channel with mode≠OFF sets cnt=0 and restarts its start level on the next cycle:
  - SQUARE: level 0.
  - PWM: high if H>0.
  - ONESHOT: the pulse restarts, giving a full H cycles.
- **i_sync and i_cfg_valid on the same edge:** the configured channel takes its new config. The other channels resync. The result is identical to the config alone for that channel.
- **Config to a channel in its final ONESHOT cycle:** the new config wins, and o_done does not pulse.
- **Reset mid-pattern:** outputs go to 0 on the edge after i_rst is sampled high. No o_done pulse is produced.

## Test plan
- **Reset:** hold i_rst for 3 cycles with random config inputs. Required: o_gpio=0 and o_done=0 throughout and after release; channels stay OFF until a write.
- **SQUARE:** configure ch0 with P=3. Required: o_gpio[0] is 0 for 4 cycles, then 1 for 4 cycles, repeating. Reconfigure to P=0 and check a toggle every cycle.
- **PWM:**
  - Configure ch1 with P=9, H=3. Required: high 3 cycles, low 7, in a 10-cycle frame.
  - With the same P=9, check H=0 gives constant low and H=12 gives constant high.
- **ONESHOT:**
  - Configure ch2 with H=5. Required: 5 high cycles, o_done[2] pulses in the 6th cycle, and the channel stays low afterwards.
  - H=0 gives an o_done pulse in the cycle after the write.
- **Hold, sync and collision:**
  - Hold for 7 cycles mid-PWM: the output and phase are resumed unchanged afterwards.
  - Apply i_sync together with a config write to ch3: ch0–ch2 restart their phases, and ch3 follows its new config.
  - A write to channel index ≥ CHANNELS (when CHANNELS is not a power of two) changes nothing.
- **Reset mid-operation:** assert i_rst during an ONESHOT high phase. Required: the output goes to 0 the next cycle, there is no o_done pulse, and the mode is OFF after release.
